tx_grant_sched: RTL and testbench
=================================

TX_GRANT_SCHED -- requirements
Module: tx_grant_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesting clients (2..8).
REQ-002 SHALL have parameter CW, default 16: requestcode/ackcode width.
REQ-003 SHALL have parameter CNTW, default 5: per-client pending-count width.
REQ-004 SHALL have parameter TOUT, default 255: cycles to wait for txbusy after a grant.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port request, input, NREQ: per-client single-cycle frame request pulse.
REQ-008 SHALL have port requestcode, input, NREQ*CW: per-client code, with client i in bits [i*CW +: CW].
REQ-009 SHALL have port requestacpt, output, NREQ: request accepted this cycle.
REQ-010 SHALL have port txbusy, input, 1: the shared transmitter is sending.
REQ-011 SHALL have port ack, output, NREQ: one-hot, single-cycle grant to a client.
REQ-012 SHALL have port ackcode, output, CW: code of the granted client, valid with and after ack.
REQ-013 SHALL have port sel, output, $clog2(NREQ): tx mux select for the granted client.
REQ-014 SHALL have port pendcnt, output, NREQ*CNTW: the per-client pending counters.
REQ-015 SHALL have port stickyclr, input, 1: clears the sticky flags.
REQ-016 SHALL have port overflow, output, 1: sticky flag, set when a request was refused because its counter was full.
REQ-017 SHALL have port timeout, output, 1: sticky flag, set when txbusy did not rise within TOUT cycles.

Function
REQ-018 SHALL drive requestacpt[i] = request[i] & (cnt[i] != 2^CNTW-1), combinationally.
REQ-019 SHALL store code[i] <= requestcode[i] on each accepted request.
REQ-020 SHALL update cnt[i] as +1 on accept, -1 on the cycle client i is in GRANT, and unchanged when both occur together.
REQ-021 SHALL refuse a request arriving while cnt[i] is full (no increment) and set overflow.
REQ-022 SHALL implement an FSM with states IDLE, GRANT, WAITBUSY and ACTIVE.
REQ-023 SHALL, in IDLE with txbusy=0 and any cnt nonzero, pick the first nonzero index scanning from (last+1) mod NREQ with wrap, latch it into idx and go to GRANT.
REQ-024 SHALL stay in IDLE while txbusy=1.
REQ-025 SHALL, in GRANT, assert ack[idx] for exactly one cycle, drive ackcode=code[idx] and sel=idx, set last<=idx, and go to WAITBUSY.
REQ-026 SHALL, in WAITBUSY, go to ACTIVE when txbusy=1, clearing the timer.
REQ-027 SHALL, in WAITBUSY, go to IDLE and set timeout when the timer reaches TOUT.
REQ-028 SHALL, in ACTIVE, go to IDLE when txbusy=0.
REQ-029 SHALL hold sel and ackcode from GRANT until the next GRANT.
REQ-030 SHALL make ack a registered output: for a request sampled at edge k into an idle scheduler, ack is high in the cycle after edge k+1.
REQ-031 SHALL not re-arbitrate before returning to IDLE, so grants never overlap a transmission.
REQ-032 SHALL clear overflow and timeout on stickyclr; a set event in the same cycle as stickyclr wins.
REQ-033 SHALL time out a client whose frame never starts; that client's grant is consumed and not retried.

Reset
REQ-034 SHALL reset asynchronously: state=IDLE, all cnt=0, all code=0, last=NREQ-1, idx=0, sel=0, ack=0, ackcode=0, timer=0, overflow=0, timeout=0.
REQ-035 SHALL, on reset mid-grant or mid-ACTIVE, drop all pending requests and wait for txbusy=0 before the first new grant, per REQ-024.

Structure
REQ-036 SHALL place the state enum (IDLE/GRANT/WAITBUSY/ACTIVE) and the default parameter constants in a shared package, ethsched_pkg.
REQ-037 SHALL implement the wrap-around pick as one combinational sub-module, rr_pick (inputs: NREQ-bit nonzero mask and last index; outputs: index and valid).

Verification
REQ-038 SHALL cover a single request: request[2] with code 0x0800 at edge 0, txbusy rising 3 cycles after ack and held 10 cycles -> ack=4'b0100 one cycle after edge 1, ackcode=0x0800, sel=2, cnt[2] goes 1 then 0.
REQ-039 SHALL cover round-robin: all 4 clients request together, each grant followed by a 5-cycle txbusy -> grant order 0,1,2,3; a new request from client 0 plus one from client 3 after grant 3 -> next grants 0 then 3.
REQ-040 SHALL cover saturation: 33 back-to-back requests to client 1 with txbusy held high -> cnt[1]=31, requestacpt low on the 32nd and 33rd, overflow=1.
REQ-041 SHALL cover timeout: a grant with txbusy held low -> timeout set TOUT cycles after WAITBUSY entry, FSM in IDLE, the next pending client granted.
REQ-042 SHALL cover a simultaneous accept and grant on the same client: cnt unchanged, then exactly one further grant.
REQ-043 SHALL cover reset asserted during ACTIVE with txbusy=1 -> all outputs at reset values, no ack until txbusy=0 and a new request.

Source files
------------

// File: rtl/ethsched_pkg.sv
// Shared types and default sizing for the transmit grant scheduler.
package ethsched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAITBUSY = 2'd2,
    ACTIVE   = 2'd3
  } sched_state_e;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 16;
  localparam int DEF_CNTW = 5;
  localparam int DEF_TOUT = 255;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set mask bit scanning from (last+1) mod NREQ with wrap.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         mask,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    valid
);
  localparam int LW = $clog2(NREQ);

  logic [LW-1:0] j;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = LW'((int'(last) + k) % NREQ);
      if (mask[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_grant_sched.sv
// Arbitrates per-client frame requests onto one shared transmitter with
// round-robin grants, per-client pending counters and sticky error flags.
module tx_grant_sched
  import ethsched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW,
  parameter int CNTW = DEF_CNTW,
  parameter int TOUT = DEF_TOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          request,
  input  logic [NREQ*CW-1:0]       requestcode,
  output logic [NREQ-1:0]          requestacpt,
  input  logic                     txbusy,
  output logic [NREQ-1:0]          ack,
  output logic [CW-1:0]            ackcode,
  output logic [$clog2(NREQ)-1:0]  sel,
  output logic [NREQ*CNTW-1:0]     pendcnt,
  input  logic                     stickyclr,
  output logic                     overflow,
  output logic                     timeout
);
  localparam int SW = $clog2(NREQ);
  localparam int TW = $clog2(TOUT + 1);

  sched_state_e state, nstate;

  logic [NREQ-1:0][CNTW-1:0] cnt;
  logic [NREQ-1:0][CW-1:0]   code;
  logic [NREQ-1:0][CW-1:0]   rcode;
  logic [NREQ-1:0]           full, nz, dec;
  logic [SW-1:0]             idx, last, pick_idx;
  logic                      pick_vld;
  logic [TW-1:0]             timer;
  logic                      tmr_done, ovf_set, to_set;

  assign rcode   = requestcode;
  assign pendcnt = cnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_cli
    assign full[i] = &cnt[i];
    assign nz[i]   = |cnt[i];
  end

  assign requestacpt = request & ~full;
  assign ovf_set     = |(request & full);
  assign tmr_done    = (timer == TW'(TOUT - 1));
  assign to_set      = (state == WAITBUSY) && !txbusy && tmr_done;

  always_comb begin
    dec = '0;
    if (state == GRANT) dec[idx] = 1'b1;
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .mask  (nz),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (!txbusy && pick_vld) nstate = GRANT;
      GRANT:    nstate = WAITBUSY;
      WAITBUSY: if (txbusy) nstate = ACTIVE;
                else if (tmr_done) nstate = IDLE;
      ACTIVE:   if (!txbusy) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  // A grant and a new accept on the same client cancel in the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      code <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (requestacpt[i]) code[i] <= rcode[i];
        if (requestacpt[i] && !dec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !requestacpt[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // ack/sel/ackcode are loaded on the edge entering GRANT so ack is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      last     <= SW'(NREQ - 1);
      sel      <= '0;
      ack      <= '0;
      ackcode  <= '0;
      timer    <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (state == IDLE && nstate == GRANT) begin
        idx     <= pick_idx;
        sel     <= pick_idx;
        ackcode <= code[pick_idx];
        ack     <= NREQ'(1) << pick_idx;
      end else begin
        ack <= '0;
      end
      if (state == GRANT) last <= idx;
      if (state == WAITBUSY && !txbusy && !tmr_done) timer <= timer + 1'b1;
      else                                           timer <= '0;
      overflow <= ovf_set | (overflow & ~stickyclr);
      timeout  <= to_set  | (timeout  & ~stickyclr);
    end
  end

endmodule

// File: tb/tb_tx_grant_sched.sv
// Directed checks of tx_grant_sched: latency, round-robin, saturation, timeout, reset.
module tb_tx_grant_sched;
  localparam int NREQ = 4;
  localparam int CW   = 16;
  localparam int CNTW = 5;
  localparam int TOUT = 255;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      request = '0;
  logic [NREQ*CW-1:0]   requestcode = '0;
  logic [NREQ-1:0]      requestacpt;
  logic                 txbusy = 1'b0;
  logic [NREQ-1:0]      ack;
  logic [CW-1:0]        ackcode;
  logic [1:0]           sel;
  logic [NREQ*CNTW-1:0] pendcnt;
  logic                 stickyclr = 1'b0;
  logic                 overflow, timeout;

  int compared   = 0;
  int mismatched = 0;
  int nacks;

  always #5 clk = ~clk;

  tx_grant_sched #(.NREQ(NREQ), .CW(CW), .CNTW(CNTW), .TOUT(TOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .requestcode (requestcode),
    .requestacpt (requestacpt),
    .txbusy      (txbusy),
    .ack         (ack),
    .ackcode     (ackcode),
    .sel         (sel),
    .pendcnt     (pendcnt),
    .stickyclr   (stickyclr),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    request   = '0;
    stickyclr = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] exp);
    int n = 0;
    while (ack == '0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, ack, exp);
  endtask

  // Called in the GRANT cycle: frame runs ~5 cycles, then the bus goes idle.
  task automatic serve();
    txbusy = 1'b1;
    repeat (5) step();
    txbusy = 1'b0;
    step();
  endtask

  task automatic count_acks(input int cycles);
    nacks = 0;
    repeat (cycles) begin
      step();
      if (ack != '0) nacks++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (2) step();
    chk("rst_ack", ack, 0);
    chk("rst_ackcode", ackcode, 0);
    chk("rst_sel", sel, 0);
    chk("rst_pendcnt", pendcnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    step();

    // single request, latency and counter
    request = 4'b0100;
    requestcode[2*CW +: CW] = 16'h0800;
    @(negedge clk);
    chk("t1_acpt", requestacpt, 4'b0100);
    step();
    request = '0;
    chk("t1_cnt_up", pendcnt, 20'h00400);
    chk("t1_noack_early", ack, 0);
    step();
    chk("t1_ack", ack, 4'b0100);
    chk("t1_ackcode", ackcode, 16'h0800);
    chk("t1_sel", sel, 2);
    step();
    chk("t1_ack_onecycle", ack, 0);
    chk("t1_cnt_down", pendcnt, 0);
    repeat (2) step();
    txbusy = 1'b1;
    repeat (10) step();
    txbusy = 1'b0;
    chk("t1_sel_hold", sel, 2);
    chk("t1_code_hold", ackcode, 16'h0800);
    chk("t1_no_timeout", timeout, 0);
    count_acks(5);
    chk("t1_no_regrant", nacks, 0);

    // round robin from reset
    do_reset();
    request = 4'b1111;
    for (int i = 0; i < NREQ; i++) requestcode[i*CW +: CW] = 16'(32'h1000 + i);
    step();
    request = '0;
    for (int g = 0; g < NREQ; g++) begin
      wait_ack($sformatf("rr_ack%0d", g), 4'(1 << g));
      chk($sformatf("rr_code%0d", g), ackcode, 32'h1000 + g);
      chk($sformatf("rr_sel%0d", g), sel, g);
      serve();
    end
    request = 4'b1001;
    requestcode[0*CW +: CW] = 16'hA000;
    requestcode[3*CW +: CW] = 16'hA003;
    step();
    request = '0;
    wait_ack("rr_next0", 4'b0001);
    chk("rr_next0_code", ackcode, 16'hA000);
    serve();
    wait_ack("rr_next3", 4'b1000);
    chk("rr_next3_code", ackcode, 16'hA003);
    serve();
    chk("rr_drained", pendcnt, 0);

    // saturation with transmitter held busy
    do_reset();
    txbusy = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      request = 4'b0010;
      requestcode[1*CW +: CW] = 16'(n);
      @(negedge clk);
      chk($sformatf("sat_acpt%0d", n), requestacpt, (n <= 31) ? 4'b0010 : 4'b0000);
      step();
    end
    request = '0;
    chk("sat_cnt", pendcnt, 20'h003E0);
    chk("sat_overflow", overflow, 1);
    chk("sat_noack", ack, 0);
    request   = 4'b0010;
    stickyclr = 1'b1;
    step();
    request = '0;
    chk("sat_set_wins", overflow, 1);
    chk("sat_cnt_held", pendcnt, 20'h003E0);
    step();
    stickyclr = 1'b0;
    chk("sat_cleared", overflow, 0);
    do_reset();
    txbusy = 1'b0;

    // timeout: grant never followed by txbusy
    do_reset();
    request = 4'b0011;
    requestcode[0*CW +: CW] = 16'hB000;
    requestcode[1*CW +: CW] = 16'hB001;
    step();
    request = '0;
    wait_ack("to_ack0", 4'b0001);
    step();
    repeat (TOUT - 1) step();
    chk("to_not_early", timeout, 0);
    step();
    chk("to_set", timeout, 1);
    chk("to_noack", ack, 0);
    chk("to_consumed", pendcnt, 20'h00020);
    step();
    chk("to_next_ack", ack, 4'b0010);
    chk("to_next_code", ackcode, 16'hB001);
    serve();
    chk("to_sticky", timeout, 1);
    stickyclr = 1'b1;
    step();
    stickyclr = 1'b0;
    chk("to_cleared", timeout, 0);

    // accept and grant on the same client in the same cycle
    do_reset();
    request = 4'b0100;
    requestcode[2*CW +: CW] = 16'h1111;
    step();
    request = '0;
    step();
    chk("same_ack", ack, 4'b0100);
    request = 4'b0100;
    requestcode[2*CW +: CW] = 16'h2222;
    txbusy  = 1'b1;
    @(negedge clk);
    chk("same_acpt", requestacpt, 4'b0100);
    step();
    request = '0;
    chk("same_cnt", pendcnt, 20'h00400);
    repeat (4) step();
    txbusy = 1'b0;
    step();
    wait_ack("same_regrant", 4'b0100);
    chk("same_code", ackcode, 16'h2222);
    serve();
    chk("same_drained", pendcnt, 0);
    count_acks(10);
    chk("same_no_extra", nacks, 0);

    // reset during ACTIVE with txbusy high
    do_reset();
    request = 4'b0001;
    requestcode[0*CW +: CW] = 16'hD000;
    step();
    request = '0;
    wait_ack("ra_ack", 4'b0001);
    txbusy = 1'b1;
    repeat (3) step();
    request = 4'b0100;
    step();
    request = '0;
    chk("ra_pending", pendcnt, 20'h00400);
    reset = 1'b1;
    #1;
    chk("ra_ack", ack, 0);
    chk("ra_ackcode", ackcode, 0);
    chk("ra_sel", sel, 0);
    chk("ra_pendcnt", pendcnt, 0);
    chk("ra_flags", {overflow, timeout}, 0);
    step();
    reset = 1'b0;
    request = 4'b0010;
    requestcode[1*CW +: CW] = 16'hC001;
    step();
    request = '0;
    count_acks(8);
    chk("ra_hold_busy", nacks, 0);
    chk("ra_newcnt", pendcnt, 20'h00020);
    txbusy = 1'b0;
    wait_ack("ra_first", 4'b0010);
    chk("ra_first_code", ackcode, 16'hC001);
    serve();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
